// File: rtl/md_issue_ctrl.sv
// Issue controller for the iterative multiply/divide unit: decodes HI/LO-class
// instructions, launches operations, tracks latency and stalls HI/LO consumers in ID.
module md_issue_ctrl #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    input  logic       issue_en,
    output logic       md_start,
    output logic [1:0] md_op,
    output logic       md_busy,
    output logic       hilo_we,
    output logic       stall_req,
    output logic       mfhiD,
    output logic       mfloD,
    output logic       mthiD,
    output logic       mtloD
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [1:0]       r_md_op;
    logic [1:0]       w_md_op_nxt;

    logic w_rtype;
    logic w_is_md;
    logic w_is_hilo_user;
    logic w_issue;

    // Decode is only meaningful for SPECIAL (R-type) instructions.
    assign w_rtype = (opcode == 6'h00);
    assign mfhiD   = w_rtype && (func == 6'h10);
    assign mthiD   = w_rtype && (func == 6'h11);
    assign mfloD   = w_rtype && (func == 6'h12);
    assign mtloD   = w_rtype && (func == 6'h13);
    assign w_is_md = w_rtype && (func[5:2] == 4'b0110);

    assign w_is_hilo_user = w_is_md || mfhiD || mthiD || mfloD || mtloD;

    // DONE is left out on purpose: HI/LO is written at the end of that cycle,
    // so a consumer leaving ID then already sees the new value in EX.
    assign stall_req = (r_state == S_BUSY) && w_is_hilo_user;
    assign w_issue   = issue_en && w_is_md && !stall_req;
    assign md_start  = w_issue;

    assign md_op   = r_md_op;
    assign md_busy = (r_state == S_BUSY);
    assign hilo_we = (r_state == S_DONE);

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_md_op_nxt = r_md_op;
        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (w_issue) begin
                    w_state_nxt = S_BUSY;
                    w_cnt_nxt   = func[1] ? DIV_LOAD : MUL_LOAD;
                    w_md_op_nxt = func[1:0];
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_BUSY: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_md_op <= 2'b00;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_md_op <= w_md_op_nxt;
        end
    end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Self-checking bench for md_issue_ctrl: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a timeline model.
module tb_md_issue_ctrl;

    localparam int MUL_CYCLES = 4;
    localparam int DIV_CYCLES = 32;
    localparam int CNT_W      = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic [5:0] func = 6'h20;
    logic       issue_en = 1'b0;
    logic       md_start;
    logic [1:0] md_op;
    logic       md_busy;
    logic       hilo_we;
    logic       stall_req;
    logic       mfhiD;
    logic       mfloD;
    logic       mthiD;
    logic       mtloD;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    md_issue_ctrl #(
        .MUL_CYCLES(MUL_CYCLES),
        .DIV_CYCLES(DIV_CYCLES),
        .CNT_W     (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .opcode   (opcode),
        .func     (func),
        .issue_en (issue_en),
        .md_start (md_start),
        .md_op    (md_op),
        .md_busy  (md_busy),
        .hilo_we  (hilo_we),
        .stall_req(stall_req),
        .mfhiD    (mfhiD),
        .mfloD    (mfloD),
        .mthiD    (mthiD),
        .mtloD    (mtloD)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Model: an operation issued in cycle T with latency L is busy in cycles
    // T+1..T+L and writes HI/LO in cycle T+L+1; a reset forgets it.
    logic m_valid = 1'b0;
    int   m_t     = 0;
    int   m_lat   = 0;
    logic [1:0] m_op = 2'b00;

    always @(negedge clk) begin
        logic rtype, e_mfhi, e_mflo, e_mthi, e_mtlo, e_md, e_user;
        logic e_busy, e_we, e_stall, e_start;
        rtype  = (opcode == 6'h00);
        e_mfhi = rtype && (func == 6'h10);
        e_mthi = rtype && (func == 6'h11);
        e_mflo = rtype && (func == 6'h12);
        e_mtlo = rtype && (func == 6'h13);
        e_md   = rtype && (func inside {6'h18, 6'h19, 6'h1A, 6'h1B});
        e_user = e_md || e_mfhi || e_mflo || e_mthi || e_mtlo;
        e_busy = m_valid && (cyc >= m_t + 1) && (cyc <= m_t + m_lat);
        e_we   = m_valid && (cyc == m_t + m_lat + 1);
        e_stall = e_busy && e_user;
        e_start = issue_en && e_md && !e_stall;

        check("m_md_start", md_start, e_start);
        check("m_stall_req", stall_req, e_stall);
        check("m_decode", {mfhiD, mthiD, mfloD, mtloD}, {e_mfhi, e_mthi, e_mflo, e_mtlo});
        check("m_md_busy", md_busy, e_busy);
        check("m_hilo_we", hilo_we, e_we);
        check("m_md_op", md_op, m_op);

        if (rst) begin
            m_valid = 1'b0;
            m_op    = 2'b00;
        end else if (e_start) begin
            m_valid = 1'b1;
            m_t     = cyc;
            m_lat   = (func == 6'h1A || func == 6'h1B) ? DIV_CYCLES : MUL_CYCLES;
            m_op    = func[1:0];
        end
    end

    // Drive one cycle's inputs just after the edge, then settle before checks.
    task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic en, input logic r);
        @(posedge clk);
        #1;
        opcode   = op;
        func     = fn;
        issue_en = en;
        rst      = r;
        #1;
    endtask

    initial begin
        drive(6'h00, 6'h20, 1'b0, 1'b1);
        drive(6'h00, 6'h20, 1'b0, 1'b0);
        check("reset_busy", md_busy, 1'b0);
        check("reset_we", hilo_we, 1'b0);
        check("reset_op", md_op, 2'b00);

        // MULT latency
        drive(6'h00, 6'h18, 1'b1, 1'b0);
        check("mult_start", md_start, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            drive(6'h00, 6'h20, 1'b1, 1'b0);
            check("mult_busy", md_busy, (k <= 4));
            check("mult_we", hilo_we, (k == 5));
            if (k == 1) check("mult_op", md_op, 2'b00);
        end

        // DIVU with MFLO waiting in ID
        drive(6'h00, 6'h1B, 1'b1, 1'b0);
        check("divu_start", md_start, 1'b1);
        for (int k = 1; k <= 33; k++) begin
            drive(6'h00, 6'h12, 1'b1, 1'b0);
            check("mflo_stall", stall_req, (k <= 32));
            check("mflo_flag", mfloD, 1'b1);
            check("divu_we", hilo_we, (k == 33));
        end
        check("divu_op", md_op, 2'b11);
        drive(6'h00, 6'h20, 1'b0, 1'b0);

        // Back-to-back MULT then DIV issued in DONE
        drive(6'h00, 6'h18, 1'b1, 1'b0);
        for (int k = 1; k <= 4; k++) drive(6'h00, 6'h20, 1'b0, 1'b0);
        drive(6'h00, 6'h1A, 1'b1, 1'b0);
        check("b2b_we", hilo_we, 1'b1);
        check("b2b_start", md_start, 1'b1);
        for (int k = 1; k <= 33; k++) begin
            drive(6'h00, 6'h20, 1'b0, 1'b0);
            check("b2b_busy", md_busy, (k <= 32));
            check("b2b_div_we", hilo_we, (k == 33));
            if (k == 1) check("b2b_op", md_op, 2'b10);
        end

        // Reset in the middle of MULTU
        drive(6'h00, 6'h19, 1'b1, 1'b0);
        drive(6'h00, 6'h20, 1'b0, 1'b0);
        drive(6'h00, 6'h20, 1'b0, 1'b1);
        check("rst_mid_busy_before", md_busy, 1'b1);
        drive(6'h00, 6'h20, 1'b0, 1'b0);
        check("rst_mid_busy", md_busy, 1'b0);
        check("rst_mid_op", md_op, 2'b00);
        for (int k = 1; k <= 10; k++) begin
            drive(6'h00, 6'h20, 1'b0, 1'b0);
            check("rst_mid_no_we", hilo_we, 1'b0);
        end

        // Non-launching instructions
        drive(6'h00, 6'h20, 1'b1, 1'b0);
        check("add_start", md_start, 1'b0);
        check("add_stall", stall_req, 1'b0);
        drive(6'h1C, 6'h18, 1'b1, 1'b0);
        check("op1c_start", md_start, 1'b0);
        check("op1c_flags", {mfhiD, mthiD, mfloD, mtloD}, 4'b0000);
        check("op1c_stall", stall_req, 1'b0);
        drive(6'h00, 6'h18, 1'b0, 1'b0);
        check("mult_noen_start", md_start, 1'b0);
        check("mult_noen_stall", stall_req, 1'b0);
        drive(6'h00, 6'h20, 1'b0, 1'b0);
        check("no_launch_busy", md_busy, 1'b0);

        // MTHI in IDLE and during BUSY
        drive(6'h00, 6'h11, 1'b1, 1'b0);
        check("mthi_idle_stall", stall_req, 1'b0);
        check("mthi_idle_start", md_start, 1'b0);
        check("mthi_idle_flag", mthiD, 1'b1);
        drive(6'h00, 6'h18, 1'b1, 1'b0);
        drive(6'h00, 6'h11, 1'b1, 1'b0);
        check("mthi_busy_stall", stall_req, 1'b1);
        check("mthi_busy_flag", mthiD, 1'b1);
        for (int k = 1; k <= 6; k++) drive(6'h00, 6'h20, 1'b0, 1'b0);

        // Randomized traffic, checked by the per-cycle model
        for (int i = 0; i < 3000; i++) begin
            logic [5:0] op;
            logic [5:0] fn;
            int sel;
            op  = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : 6'h00;
            sel = $urandom_range(0, 9);
            if (sel < 4)       fn = 6'h10 + 6'(sel);
            else if (sel < 8)  fn = 6'h18 + 6'(sel - 4);
            else if (sel == 8) fn = 6'h20;
            else               fn = 6'($urandom_range(0, 63));
            drive(op, fn, ($urandom_range(0, 3) != 0), ($urandom_range(0, 63) == 0));
        end
        for (int k = 0; k < 40; k++) drive(6'h00, 6'h20, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/md_issue_ctrl.md
Name: md_issue_ctrl

Overview:
Multi-cycle multiply/divide issue controller, parametrised in operation latency.
- Sits beside the ID-stage decoder and extends the pipeline with MULT/MULTU/DIV/DIVU and the HI/LO transfer instructions.
- Decodes HI/LO-class instructions, launches the iterative MD unit, tracks its latency with a down-counter FSM, and raises a stall request while any HI/LO consumer sits in ID during an operation.
- Generates the single-cycle HI/LO write enable at completion.

Parameters:
MUL_CYCLES, 4, cycles MULT/MULTU spends in BUSY; legal range 1..2^CNT_W.
DIV_CYCLES, 32, cycles DIV/DIVU spends in BUSY; legal range 1..2^CNT_W.
CNT_W, 6, latency counter width.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous, active-high reset.
opcode  in  6  ID-stage instruction opcode.
func  in  6  ID-stage R-type function field.
issue_en  in  1  ID instruction advances to EX this cycle. Valid, not flushed, not stalled by other hazard sources. Excludes this block's own stall_req.
md_start  out  1  combinational one-cycle launch pulse to MD datapath.
md_op  out  2  registered operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
md_busy  out  1  registered; high while in BUSY.
hilo_we  out  1  registered; one-cycle HI/LO write enable (DONE state).
stall_req  out  1  combinational ID stall request to hazard unit.
mfhiD, mfloD, mthiD, mtloD  out  1 each  combinational decode flags.

Behaviour:
- Decode applies only when opcode==6'h00. Function codes: MFHI 6'h10, MTHI 6'h11, MFLO 6'h12, MTLO 6'h13, MULT 6'h18, MULTU 6'h19, DIV 6'h1A, DIVU 6'h1B.
- is_md: func is one of 18–1B. is_hilo_user: is_md OR any of 10–13.
- FSM states: IDLE, BUSY, DONE. Registers: state, cnt[CNT_W-1:0], md_op.
- stall_req = (state==BUSY) && is_hilo_user. Not asserted in IDLE or DONE.
  - DONE writes HI/LO at the end of that cycle, so a consumer leaving ID then reads the updated value in EX.
- Issue condition: issue = issue_en && is_md && !stall_req. md_start = issue.
- On an issue edge:
  - md_op <= func[1:0].
  - cnt <= (func[1] ? DIV_CYCLES : MUL_CYCLES) - 1.
  - state <= BUSY.
- IDLE: issue -> BUSY; otherwise stay.
- BUSY: if cnt==0 -> DONE; else cnt <= cnt-1. Any issue attempt is blocked by stall_req.
- DONE: hilo_we=1 for exactly this cycle. Then issue -> BUSY (back-to-back, no gap); otherwise -> IDLE.
- Latency: issue at cycle T gives BUSY for T+1..T+LAT and DONE/hilo_we at T+LAT+1.
- md_busy = (state==BUSY). md_op holds its value until the next issue.
- Reset (synchronous, any state including mid-operation), at the next edge:
  - state=IDLE, cnt=0, md_op=2'b00.
  - md_busy=0, hilo_we=0.
  - The in-flight result is abandoned; no hilo_we is ever produced for it.
- Reset priority: rst is checked before issue on the same edge.
- Combinational outputs follow their inputs during reset: md_start, stall_req, decode flags.
- issue_en=0 with an MD instruction in ID: no launch, state unchanged.
- opcode!=0 with a matching func value: all decode flags 0, no launch, no stall.
- The counter never wraps: reload happens only on issue, and decrement stops at 0.

Test Plan:
- MUL_CYCLES=4, issue MULT (op 0, func 18) with issue_en=1 at T:
  - md_start=1 at T, md_op=00 from T+1.
  - md_busy=1 for T+1..T+4, hilo_we=1 only at T+5.
- DIV_CYCLES=32, issue DIVU at T, then MFLO held in ID with issue_en=1:
  - stall_req=1 and mfloD=1 for T+1..T+32.
  - stall_req=0 and hilo_we=1 at T+33.
- MULT completes (DONE at cycle D) with DIV in ID and issue_en=1 at D:
  - md_start=1 at D; md_busy=1 at D+1 with no IDLE gap; md_op=10.
  - hilo_we=1 at D+33.
- MULTU issued; rst=1 on the second BUSY cycle:
  - Next cycle state IDLE, md_busy=0, md_op=00.
  - hilo_we stays 0 for 10 further cycles.
- ADD (func 20), opcode 6'h1C with func 18, and MULT with issue_en=0:
  - No md_start, no state change, stall_req=0 in every case.
- MTHI in ID during BUSY: stall_req=1, mthiD=1. MTHI in ID during IDLE: stall_req=0, md_start=0.
